// File: rtl/trans_seq.sv
// Tile sequencer for the t8x8 transpose array: loads N rows (zero-padding short tiles),
// then drains N transposed rows under backpressure (flushing rows the consumer did not ask for).
module trans_seq #(
   parameter int N  = 8,
   parameter int W  = 32,
   parameter int CW = $clog2(N) + 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            enable_i,
   input  logic            start_i,
   input  logic [CW-1:0]   cfg_rows_i,
   input  logic [CW-1:0]   cfg_cols_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [N*W-1:0]  in_row_i,
   output logic            arr_enable_o,
   output logic [N*W-1:0]  arr_x_o,
   output logic [N-1:0]    arr_v_o,
   output logic [N-1:0]    arr_clear_o,
   output logic [N-1:0]    arr_shift_o,
   input  logic [N*W-1:0]  arr_y_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [N*W-1:0]  out_row_o,
   output logic            busy_o,
   output logic            done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_PAD, S_DRAIN, S_FLUSH, S_DONE
   } state_e;

   localparam logic [CW-1:0] NC  = CW'(N);
   localparam logic [CW-1:0] ONE = CW'(1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rows_q, rows_d;
   logic [CW-1:0] cols_q, cols_d;

   // Zero and out-of-range configurations both mean a full tile.
   function automatic logic [CW-1:0] clamp_cfg(input logic [CW-1:0] v);
      return ((v == '0) || (v > NC)) ? NC : v;
   endfunction

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of every other register regardless of block order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rows_q  <= '0;
         cols_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
      end
   end

   // NOTE: every signal written here gets a hold/default value first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      cols_d  = cols_q;
      if (enable_i) begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  rows_d  = clamp_cfg(cfg_rows_i);
                  cols_d  = clamp_cfg(cfg_cols_i);
                  cnt_d   = '0;
                  state_d = S_CLEAR;
               end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
               if (in_valid_i) begin
                  if (cnt_q == rows_q - ONE) begin
                     cnt_d   = '0;
                     state_d = (rows_q == NC) ? S_DRAIN : S_PAD;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
            end
            S_PAD: begin
               if (cnt_q == NC - rows_q - ONE) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_DRAIN: begin
               if (out_ready_i) begin
                  if (cnt_q == cols_q - ONE) begin
                     cnt_d   = '0;
                     state_d = (cols_q == NC) ? S_DONE : S_FLUSH;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
            end
            S_FLUSH: begin
               if (cnt_q == NC - cols_q - ONE) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Handshake and array controls are state decodes gated by enable, so a frozen
   // block neither accepts, delivers nor disturbs the array.
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      arr_x_o     = '0;
      arr_v_o     = '0;
      arr_clear_o = '0;
      arr_shift_o = '0;
      done_o      = 1'b0;
      busy_o      = (state_q != S_IDLE);
      case (state_q)
         S_CLEAR: arr_clear_o = {N{enable_i}};
         S_LOAD: begin
            in_ready_o = enable_i;
            arr_x_o    = in_row_i;
            arr_v_o    = {N{in_valid_i & enable_i}};
         end
         S_PAD:   arr_v_o = {N{enable_i}};
         S_DRAIN: begin
            out_valid_o = enable_i;
            arr_shift_o = {N{out_ready_i & enable_i}};
         end
         S_FLUSH: arr_shift_o = {N{enable_i}};
         S_DONE:  done_o = enable_i;
         default: ;
      endcase
   end

   assign arr_enable_o = enable_i;
   assign out_row_o    = arr_y_i;

endmodule

// File: tb/tb_trans_seq.sv
// Bench for trans_seq: a behavioural transpose array closes the loop, and a scoreboard
// of expected transposed rows is compared against every delivered output row.
module tb_trans_seq;
   localparam int N  = 8;
   localparam int W  = 32;
   localparam int CW = $clog2(N) + 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           enable = 1'b1;
   logic           start = 1'b0;
   logic [CW-1:0]  cfg_rows = '0;
   logic [CW-1:0]  cfg_cols = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N*W-1:0] in_row = '0;
   logic           arr_enable;
   logic [N*W-1:0] arr_x;
   logic [N-1:0]   arr_v, arr_clear, arr_shift;
   logic [N*W-1:0] arr_y;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N*W-1:0] out_row;
   logic           busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   trans_seq #(.N(N), .W(W), .CW(CW)) dut (
      .clk_i(clk), .reset_i(reset), .enable_i(enable), .start_i(start),
      .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_row_i(in_row),
      .arr_enable_o(arr_enable), .arr_x_o(arr_x), .arr_v_o(arr_v),
      .arr_clear_o(arr_clear), .arr_shift_o(arr_shift), .arr_y_i(arr_y),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row),
      .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   // Behavioural array: rows written in load order, columns read out in shift order.
   logic [W-1:0] mem [N][N];
   int lp = 0;
   int dp = 0;
   always @(posedge clk) begin
      if (arr_enable) begin
         if (arr_clear != '0) begin
            lp <= 0;
            dp <= 0;
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) mem[r][c] <= '0;
         end else begin
            if (arr_v != '0 && lp < N) begin
               for (int c = 0; c < N; c++) mem[lp][c] <= arr_x[c*W +: W];
               lp <= lp + 1;
            end
            if (arr_shift != '0) dp <= dp + 1;
         end
      end
   end
   always_comb begin
      arr_y = '0;
      for (int r = 0; r < N; r++) arr_y[r*W +: W] = (dp < N) ? mem[r][dp] : '0;
   end

   // Scoreboard: expected rows pushed at tile start, popped on every output fire.
   logic [N*W-1:0] exp_q [$];
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         logic [N*W-1:0] e;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_row: unexpected output row %h", out_row);
         end else begin
            e = exp_q.pop_front();
            if (out_row !== e) $display("FAIL sb_row: got %h want %h", out_row, e);
            else n_pass++;
         end
      end
   end

   int n_clear, n_v, n_in, n_pad, n_out, n_shift_ff, n_flush, n_done;
   int n_bad_x, n_bad_shift, n_bad_frz, done_t, exp_done, seed = 1;
   logic busy_after;
   logic [6:0] rst_snap;
   logic [N*W-1:0] rst_x;

   function automatic int clampf(input int v);
      return (v == 0 || v > N) ? N : v;
   endfunction

   // Drives one tile and collects observations; the scenario tasks judge them.
   task automatic run_tile(input int rcfg, input int ccfg, input logic [15:0] ivpat,
                           input logic [15:0] orpat, input bit frz, input bit start_busy,
                           input int rst_at);
      logic [N*W-1:0] rowd [N];
      logic [N*W-1:0] e;
      int rr, cc, t, ri, i, f, load_len, drain_len, ds;
      rr = clampf(rcfg);
      cc = clampf(ccfg);
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++) rowd[r][j*W +: W] = W'(seed * 256 + 16 * r + j);
      seed++;
      for (int k = 0; k < cc; k++) begin
         e = '0;
         for (int r = 0; r < rr; r++) e[r*W +: W] = rowd[r][k*W +: W];
         exp_q.push_back(e);
      end
      i = 0; f = 0;
      while (f < rr) begin if (i >= 16 || ivpat[i]) f++; i++; end
      load_len = i;
      i = 0; f = 0;
      while (f < cc) begin if (i >= 16 || orpat[i]) f++; i++; end
      drain_len = i;
      ds = 2 + load_len + (N - rr) + (frz ? 4 : 0);
      exp_done = ds + drain_len + (N - cc) + (frz ? 4 : 0);
      {n_clear, n_v, n_in, n_pad, n_out, n_shift_ff, n_flush, n_done} = '0;
      {n_bad_x, n_bad_shift, n_bad_frz} = '0;
      done_t = -1; busy_after = 1'bx; ri = 0;

      @(posedge clk); #1;
      t = 0;
      start = 1'b1; cfg_rows = CW'(rcfg); cfg_cols = CW'(ccfg);
      enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_row = rowd[0];
      while (t < 300) begin
         @(negedge clk);
         if (rst_at >= 0 && t == rst_at + 1) begin
            rst_snap = {in_ready, out_valid, arr_v != '0, arr_clear != '0, arr_shift != '0, done, busy};
            rst_x = arr_x;
            break;
         end
         if (arr_clear == '1) n_clear++;
         if (arr_v == '1) n_v++;
         if (in_valid && in_ready) begin
            n_in++;
            if (ri < N && arr_x !== rowd[ri]) n_bad_x++;
            ri++;
         end
         if (busy && arr_v == '1 && !in_ready && arr_x == '0) n_pad++;
         if (out_valid && out_ready) n_out++;
         if (out_valid && arr_shift == '1) n_shift_ff++;
         if (out_valid && !out_ready && arr_shift != '0) n_bad_shift++;
         if (busy && arr_shift == '1 && !out_valid) n_flush++;
         if (!enable && {in_ready, out_valid, arr_v, arr_clear, arr_shift, done} != '0) n_bad_frz++;
         if (arr_enable !== enable) n_bad_frz++;
         if (enable && !in_ready && arr_x != '0) n_bad_x++;
         if (done) begin n_done++; if (done_t < 0) done_t = t; end
         if (done_t >= 0 && t == done_t + 1) begin busy_after = busy; break; end
         @(posedge clk); #1;
         t++;
         start = start_busy && (t == 10 || t == exp_done);
         cfg_rows = CW'(1); cfg_cols = CW'(1);
         in_row = rowd[(ri < N) ? ri : N - 1];
         enable = !(frz && ((t >= 4 && t <= 7) || (t >= ds + 2 && t <= ds + 5)));
         in_valid = (t >= 2 && t - 2 < 16) ? ivpat[t - 2] : 1'b1;
         out_ready = (t >= ds && t - ds < 16) ? orpat[t - ds] : 1'b1;
         if (t == rst_at) reset = 1'b1;
      end
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, arr_v, arr_clear, arr_shift, arr_x, busy, done} !== '0)
         $display("FAIL reset_outputs: got nonzero outputs in reset");
      else n_pass++;
      n_checks++;
      if (arr_enable !== 1'b1) $display("FAIL reset_arr_enable_hi: got %b want 1", arr_enable);
      else n_pass++;
      enable = 1'b0; #1;
      n_checks++;
      if (arr_enable !== 1'b0) $display("FAIL reset_arr_enable_lo: got %b want 0", arr_enable);
      else n_pass++;
      enable = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_full_tile();
      run_tile(0, 0, '1, '1, 0, 0, -1);
      n_checks++; if (n_clear !== 1) $display("FAIL full_clear: got %0d want 1", n_clear); else n_pass++;
      n_checks++; if (n_v !== 8) $display("FAIL full_v_beats: got %0d want 8", n_v); else n_pass++;
      n_checks++; if (n_shift_ff !== 8) $display("FAIL full_shift: got %0d want 8", n_shift_ff); else n_pass++;
      n_checks++; if (done_t !== 18) $display("FAIL full_latency: got %0d want 18", done_t); else n_pass++;
      n_checks++; if (busy_after !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy_after); else n_pass++;
      n_checks++; if (n_bad_x !== 0) $display("FAIL full_arr_x: got %0d bad cycles want 0", n_bad_x); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL full_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_partial_load();
      run_tile(3, 0, '1, '1, 0, 0, -1);
      n_checks++; if (n_in !== 3) $display("FAIL pload_fires: got %0d want 3", n_in); else n_pass++;
      n_checks++; if (n_pad !== 5) $display("FAIL pload_pad: got %0d want 5", n_pad); else n_pass++;
      n_checks++; if (n_v !== 8) $display("FAIL pload_v_beats: got %0d want 8", n_v); else n_pass++;
      n_checks++; if (done_t !== 18) $display("FAIL pload_latency: got %0d want 18", done_t); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL pload_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_partial_drain();
      run_tile(0, 5, '1, '1, 0, 0, -1);
      n_checks++; if (n_out !== 5) $display("FAIL pdrain_fires: got %0d want 5", n_out); else n_pass++;
      n_checks++; if (n_flush !== 3) $display("FAIL pdrain_flush: got %0d want 3", n_flush); else n_pass++;
      n_checks++; if (done_t !== 18) $display("FAIL pdrain_latency: got %0d want 18", done_t); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL pdrain_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   // Pattern 1,0,0,1 repeating on both sides: 8 stalls per side; cfg_rows=15 clamps to 8.
   task automatic test_backpressure();
      run_tile(15, 0, 16'h9999, 16'h9999, 0, 0, -1);
      n_checks++; if (n_in !== 8) $display("FAIL bp_in_fires: got %0d want 8", n_in); else n_pass++;
      n_checks++; if (n_out !== 8) $display("FAIL bp_out_fires: got %0d want 8", n_out); else n_pass++;
      n_checks++; if (n_bad_shift !== 0) $display("FAIL bp_stall_shift: got %0d want 0", n_bad_shift); else n_pass++;
      n_checks++; if (done_t !== 34) $display("FAIL bp_latency: got %0d want 34", done_t); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_enable_freeze();
      run_tile(0, 0, '1, '1, 1, 1, -1);
      n_checks++; if (n_bad_frz !== 0) $display("FAIL frz_controls: got %0d bad cycles want 0", n_bad_frz); else n_pass++;
      n_checks++; if (done_t !== 26) $display("FAIL frz_latency: got %0d want 26", done_t); else n_pass++;
      n_checks++; if (n_done !== 1) $display("FAIL frz_done_count: got %0d want 1", n_done); else n_pass++;
      n_checks++; if (busy_after !== 1'b0) $display("FAIL frz_start_at_done: busy %b want 0", busy_after); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL frz_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      run_tile(0, 0, '1, '1, 0, 0, 11);
      n_checks++; if (n_out !== 2) $display("FAIL rmid_fires: got %0d want 2", n_out); else n_pass++;
      n_checks++; if (rst_snap !== '0) $display("FAIL rmid_outputs: got %b want 0", rst_snap); else n_pass++;
      n_checks++; if (rst_x !== '0) $display("FAIL rmid_arr_x: got %h want 0", rst_x); else n_pass++;
      n_checks++; if (exp_q.size() !== 6) $display("FAIL rmid_sb_left: got %0d want 6", exp_q.size()); else n_pass++;
      exp_q.delete();
      run_tile(0, 0, '1, '1, 0, 0, -1);
      n_checks++; if (done_t !== 18) $display("FAIL rmid_next_latency: got %0d want 18", done_t); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL rmid_next_sb_left: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_tile();
      test_partial_load();
      test_partial_drain();
      test_backpressure();
      test_enable_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
